// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions for the master bridge: response codes, the
// default protection value and one-hot state encodings for the write and
// read state machines.
// Ports: none (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [3:0] {
    W_IDLE = 4'b0001,
    W_SEND = 4'b0010,
    W_RESP = 4'b0100,
    W_DONE = 4'b1000
  } wr_state_e;

  typedef enum logic [3:0] {
    R_IDLE = 4'b0001,
    R_ADDR = 4'b0010,
    R_DATA = 4'b0100,
    R_DONE = 4'b1000
  } rd_state_e;

  // Error flag reported to the core: set for SLVERR and DECERR (RESP[1]).
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_bridge_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels). Clock and reset are kept
// outside the interface as plain module ports.
// Modports:
//   master - drives AW/W/AR payload and VALIDs, BREADY, RREADY
//   slave  - drives AWREADY, WREADY, BVALID/BRESP, ARREADY, RVALID/RDATA/RRESP
// -----------------------------------------------------------------------------
interface axi_lite_master_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
);

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;

  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;

  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, input AWREADY,
    output WVALID, WDATA, WSTRB, input WREADY,
    input BVALID, BRESP, output BREADY,
    output ARVALID, ARADDR, ARPROT, input ARREADY,
    input RVALID, RDATA, RRESP, output RREADY
  );

  modport slave (
    input AWVALID, AWADDR, AWPROT, output AWREADY,
    input WVALID, WDATA, WSTRB, output WREADY,
    output BVALID, BRESP, input BREADY,
    input ARVALID, ARADDR, ARPROT, output ARREADY,
    output RVALID, RDATA, RRESP, input RREADY
  );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_master_bridge
// Bridges core read/write request ports onto an AXI4-Lite master interface.
// The write and read paths each run their own FSM; AW and W handshakes are
// tracked independently and completion is reported only after B/R arrives.
// With SERIALIZE=1 at most one transaction is in flight and a simultaneous
// read/write request is resolved in favour of the write.
// Ports:
//   ACLK, ARESET                      clock, async active-high reset
//   rd_req_*  / rd_rsp_*              core read request / response
//   wr_req_*  / wr_rsp_*              core write request / completion
//   m_axi                             AXI4-Lite master bus
// -----------------------------------------------------------------------------
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int STRB_W    = DATA_W / 8,
  parameter bit SERIALIZE = 1'b0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [ADDR_W-1:0]        rd_req_addr,
  output logic                     rd_rsp_valid,
  input  logic                     rd_rsp_ready,
  output logic [DATA_W-1:0]        rd_rsp_data,
  output logic                     rd_rsp_err,
  input  logic                     wr_req_valid,
  output logic                     wr_req_ready,
  input  logic [ADDR_W-1:0]        wr_req_addr,
  input  logic [DATA_W-1:0]        wr_req_data,
  input  logic [STRB_W-1:0]        wr_req_strb,
  output logic                     wr_rsp_valid,
  input  logic                     wr_rsp_ready,
  output logic                     wr_rsp_err,
  axi_lite_master_bridge_if.master m_axi
);

  wr_state_e         wr_state, wr_state_nxt;
  rd_state_e         rd_state, rd_state_nxt;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_grant_ok, rd_grant_ok;

  // Acceptance gates: ready is held low during reset, and in serialise mode
  // each path waits for the other to be idle; a pending write beats a read.
  always_comb begin
    wr_grant_ok = !ARESET;
    rd_grant_ok = !ARESET;
    if (SERIALIZE) begin
      wr_grant_ok = wr_grant_ok && (rd_state == R_IDLE);
      rd_grant_ok = rd_grant_ok && (wr_state == W_IDLE) && !wr_req_valid;
    end
  end

  // ---------------------------------------------------------------- write path
  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_state_nxt  = wr_state;
    wr_req_ready  = 1'b0;
    m_axi.AWVALID = 1'b0;
    m_axi.WVALID  = 1'b0;
    m_axi.BREADY  = 1'b0;
    wr_rsp_valid  = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        wr_req_ready = wr_grant_ok;
        if (wr_req_valid && wr_grant_ok) wr_state_nxt = W_SEND;
      end
      W_SEND: begin
        m_axi.AWVALID = !aw_done;
        m_axi.WVALID  = !w_done;
        // Covers AW and W completing in the same cycle as well as separately.
        if ((aw_done || m_axi.AWREADY) && (w_done || m_axi.WREADY))
          wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        m_axi.BREADY = 1'b1;
        if (m_axi.BVALID) wr_state_nxt = W_DONE;
      end
      W_DONE: begin
        wr_rsp_valid = 1'b1;
        if (wr_rsp_ready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // NOTE: state and payload use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: payload registers are reset too, because the bus addresses, write
  // data/strobe and read data must read as zero while reset is held.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state   <= W_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_strb    <= '0;
      wr_rsp_err <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      unique case (wr_state)
        W_IDLE: if (wr_req_valid && wr_req_ready) begin
          wr_addr <= wr_req_addr;
          wr_data <= wr_req_data;
          wr_strb <= wr_req_strb;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        W_SEND: begin
          if (m_axi.AWVALID && m_axi.AWREADY) aw_done <= 1'b1;
          if (m_axi.WVALID && m_axi.WREADY)   w_done  <= 1'b1;
        end
        W_RESP: if (m_axi.BVALID) wr_rsp_err <= resp_is_err(m_axi.BRESP);
        default: ;
      endcase
    end
  end

  assign m_axi.AWADDR = wr_addr;
  assign m_axi.AWPROT = PROT_DEFAULT;
  assign m_axi.WDATA  = wr_data;
  assign m_axi.WSTRB  = wr_strb;

  // ----------------------------------------------------------------- read path
  always_comb begin
    rd_state_nxt  = rd_state;
    rd_req_ready  = 1'b0;
    m_axi.ARVALID = 1'b0;
    m_axi.RREADY  = 1'b0;
    rd_rsp_valid  = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        rd_req_ready = rd_grant_ok;
        if (rd_req_valid && rd_grant_ok) rd_state_nxt = R_ADDR;
      end
      R_ADDR: begin
        m_axi.ARVALID = 1'b1;
        if (m_axi.ARREADY) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        m_axi.RREADY = 1'b1;
        if (m_axi.RVALID) rd_state_nxt = R_DONE;
      end
      R_DONE: begin
        rd_rsp_valid = 1'b1;
        if (rd_rsp_ready) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state    <= R_IDLE;
      rd_addr     <= '0;
      rd_rsp_data <= '0;
      rd_rsp_err  <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      unique case (rd_state)
        R_IDLE: if (rd_req_valid && rd_req_ready) rd_addr <= rd_req_addr;
        // rd_rsp_data keeps the last value until the next read returns.
        R_DATA: if (m_axi.RVALID) begin
          rd_rsp_data <= m_axi.RDATA;
          rd_rsp_err  <= resp_is_err(m_axi.RRESP);
        end
        default: ;
      endcase
    end
  end

  assign m_axi.ARADDR = rd_addr;
  assign m_axi.ARPROT = PROT_DEFAULT;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_bridge
// Directed bench for axi_lite_master_bridge. Two instances: dut (independent
// paths) and sdut (SERIALIZE=1). The bench plays the AXI slave by hand:
// inputs change 1 ns after a rising edge, outputs are sampled on the falling
// edge. The slave raises RVALID/BVALID one cycle after RREADY/BREADY first
// appear, so a response lands 3 edges after the core handshake edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_bridge;
  import axi_lite_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  logic ACLK   = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  int total  = 0;
  int passed = 0;

  // ---- independent-path instance
  logic              rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready, rd_rsp_err;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              wr_req_valid, wr_req_ready, wr_rsp_valid, wr_rsp_ready, wr_rsp_err;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [STRB_W-1:0] wr_req_strb;

  axi_lite_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) bus ();

  axi_lite_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .SERIALIZE(1'b0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_err(rd_rsp_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_err(wr_rsp_err),
    .m_axi(bus)
  );

  // ---- serialising instance
  logic              s_rd_req_valid, s_rd_req_ready, s_rd_rsp_valid, s_rd_rsp_ready, s_rd_rsp_err;
  logic [ADDR_W-1:0] s_rd_req_addr;
  logic [DATA_W-1:0] s_rd_rsp_data;
  logic              s_wr_req_valid, s_wr_req_ready, s_wr_rsp_valid, s_wr_rsp_ready, s_wr_rsp_err;
  logic [ADDR_W-1:0] s_wr_req_addr;
  logic [DATA_W-1:0] s_wr_req_data;
  logic [STRB_W-1:0] s_wr_req_strb;

  axi_lite_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) sbus ();

  axi_lite_master_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .SERIALIZE(1'b1)
  ) sdut (
    .ACLK(ACLK), .ARESET(ARESET),
    .rd_req_valid(s_rd_req_valid), .rd_req_ready(s_rd_req_ready), .rd_req_addr(s_rd_req_addr),
    .rd_rsp_valid(s_rd_rsp_valid), .rd_rsp_ready(s_rd_rsp_ready), .rd_rsp_data(s_rd_rsp_data),
    .rd_rsp_err(s_rd_rsp_err),
    .wr_req_valid(s_wr_req_valid), .wr_req_ready(s_wr_req_ready), .wr_req_addr(s_wr_req_addr),
    .wr_req_data(s_wr_req_data), .wr_req_strb(s_wr_req_strb),
    .wr_rsp_valid(s_wr_rsp_valid), .wr_rsp_ready(s_wr_rsp_ready), .wr_rsp_err(s_wr_rsp_err),
    .m_axi(sbus)
  );

  // ---------------------------------------------------------------- helpers
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic sample();
    @(negedge ACLK);
  endtask

  task automatic init_inputs();
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
    wr_rsp_ready = 1'b0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
    s_rd_req_valid = 1'b0; s_rd_req_addr = '0; s_rd_rsp_ready = 1'b0;
    s_wr_req_valid = 1'b0; s_wr_req_addr = '0; s_wr_req_data = '0; s_wr_req_strb = '0;
    s_wr_rsp_ready = 1'b0;
    sbus.AWREADY = 1'b0; sbus.WREADY = 1'b0; sbus.BVALID = 1'b0; sbus.BRESP = 2'b00;
    sbus.ARREADY = 1'b0; sbus.RVALID = 1'b0; sbus.RDATA = '0; sbus.RRESP = 2'b00;
  endtask

  // Zero-wait write: AW and W accepted together on the first bus cycle.
  task automatic run_write(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [1:0] resp,
                           input logic exp_err, input string tag);
    step();
    wr_req_valid = 1'b1; wr_req_addr = addr; wr_req_data = data; wr_req_strb = strb;
    sample();
    total++; if (wr_req_ready !== 1'b1) $display("FAIL %s wr_req_ready: got %b want 1", tag, wr_req_ready); else passed++;
    step();                                   // core handshake edge T passed
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
    sample();
    total++; if ({bus.AWVALID, bus.WVALID} !== 2'b11) $display("FAIL %s aw_w_valid: got %b want 11", tag, {bus.AWVALID, bus.WVALID}); else passed++;
    total++; if ({bus.AWADDR, bus.WDATA, bus.WSTRB} !== {addr, data, strb}) $display("FAIL %s aw_w_payload: got %h/%h/%h want %h/%h/%h", tag, bus.AWADDR, bus.WDATA, bus.WSTRB, addr, data, strb); else passed++;
    step();                                   // T+1: AW and W handshake together
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    sample();
    total++; if ({bus.AWVALID, bus.WVALID, bus.BREADY} !== 3'b001) $display("FAIL %s w_resp_entry: got %b want 001", tag, {bus.AWVALID, bus.WVALID, bus.BREADY}); else passed++;
    step();                                   // T+2
    bus.BVALID = 1'b1; bus.BRESP = resp;
    sample();
    total++; if (wr_rsp_valid !== 1'b0) $display("FAIL %s wr_rsp_early: got %b want 0", tag, wr_rsp_valid); else passed++;
    step();                                   // T+3: B handshake
    bus.BVALID = 1'b0; bus.BRESP = 2'b00; wr_rsp_ready = 1'b1;
    sample();
    total++; if ({wr_rsp_valid, bus.BREADY} !== 2'b10) $display("FAIL %s wr_rsp_valid_t3: got %b want 10", tag, {wr_rsp_valid, bus.BREADY}); else passed++;
    total++; if (wr_rsp_err !== exp_err) $display("FAIL %s wr_rsp_err: got %b want %b", tag, wr_rsp_err, exp_err); else passed++;
    step();
    wr_rsp_ready = 1'b0;
    sample();
    total++; if ({wr_rsp_valid, wr_req_ready} !== 2'b01) $display("FAIL %s wr_back_idle: got %b want 01", tag, {wr_rsp_valid, wr_req_ready}); else passed++;
  endtask

  // Zero-wait read, then rd_rsp_ready held low for 'hold' cycles.
  task automatic run_read(input logic [63:0] addr, input logic [63:0] data,
                          input logic [1:0] resp, input logic exp_err,
                          input int hold, input string tag);
    step();
    rd_req_valid = 1'b1; rd_req_addr = addr;
    sample();
    total++; if (rd_req_ready !== 1'b1) $display("FAIL %s rd_req_ready: got %b want 1", tag, rd_req_ready); else passed++;
    step();                                   // core handshake edge T passed
    rd_req_valid = 1'b0; rd_req_addr = '0; bus.ARREADY = 1'b1;
    sample();
    total++; if ({bus.ARVALID, bus.RREADY} !== 2'b10) $display("FAIL %s arvalid: got %b want 10", tag, {bus.ARVALID, bus.RREADY}); else passed++;
    total++; if (bus.ARADDR !== addr) $display("FAIL %s araddr: got %h want %h", tag, bus.ARADDR, addr); else passed++;
    step();                                   // T+1: AR handshake
    bus.ARREADY = 1'b0;
    sample();
    total++; if ({bus.ARVALID, bus.RREADY} !== 2'b01) $display("FAIL %s rready_entry: got %b want 01", tag, {bus.ARVALID, bus.RREADY}); else passed++;
    step();                                   // T+2
    bus.RVALID = 1'b1; bus.RDATA = data; bus.RRESP = resp;
    sample();
    total++; if (rd_rsp_valid !== 1'b0) $display("FAIL %s rd_rsp_early: got %b want 0", tag, rd_rsp_valid); else passed++;
    step();                                   // T+3: R handshake
    bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
    sample();
    total++; if ({rd_rsp_valid, bus.RREADY} !== 2'b10) $display("FAIL %s rd_rsp_valid_t3: got %b want 10", tag, {rd_rsp_valid, bus.RREADY}); else passed++;
    total++; if ({rd_rsp_data, rd_rsp_err} !== {data, exp_err}) $display("FAIL %s rd_rsp_data_err: got %h/%b want %h/%b", tag, rd_rsp_data, rd_rsp_err, data, exp_err); else passed++;
    for (int i = 0; i < hold; i++) begin
      step();
      sample();
      total++; if ({rd_rsp_valid, bus.ARVALID} !== 2'b10) $display("FAIL %s hold%0d_valid: got %b want 10", tag, i, {rd_rsp_valid, bus.ARVALID}); else passed++;
      total++; if (rd_rsp_data !== data) $display("FAIL %s hold%0d_data: got %h want %h", tag, i, rd_rsp_data, data); else passed++;
    end
    step();
    rd_rsp_ready = 1'b1;
    sample();
    step();
    rd_rsp_ready = 1'b0;
    sample();
    total++; if ({rd_rsp_valid, rd_req_ready} !== 2'b01) $display("FAIL %s rd_back_idle: got %b want 01", tag, {rd_rsp_valid, rd_req_ready}); else passed++;
    total++; if (rd_rsp_data !== data) $display("FAIL %s rd_data_kept: got %h want %h", tag, rd_rsp_data, data); else passed++;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    logic [10:0] ctl;
    sample();
    ctl = {rd_req_ready, wr_req_ready, rd_rsp_valid, wr_rsp_valid, rd_rsp_err, wr_rsp_err,
           bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY};
    total++; if (ctl !== 11'b0) $display("FAIL reset_ctl: got %b want 0", ctl); else passed++;
    total++; if ({bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, rd_rsp_data} !== '0) $display("FAIL reset_payload: got %h/%h/%h/%h/%h want 0", bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, rd_rsp_data); else passed++;
    step();
    ARESET = 1'b0;
    sample();
    total++; if ({rd_req_ready, wr_req_ready, s_rd_req_ready, s_wr_req_ready} !== 4'b1111) $display("FAIL post_reset_ready: got %b want 1111", {rd_req_ready, wr_req_ready, s_rd_req_ready, s_wr_req_ready}); else passed++;
    total++; if ({bus.AWPROT, bus.ARPROT} !== 6'b0) $display("FAIL prot: got %b want 0", {bus.AWPROT, bus.ARPROT}); else passed++;
  endtask

  task automatic test_single_read();
    run_read(64'h0000_0000_8000_0000, 64'h1122_3344_5566_7788, OKAY, 1'b0, 0, "single_read");
  endtask

  // WREADY arrives two cycles before AWREADY; AW must hold steady meanwhile.
  task automatic test_write_w_first();
    step();
    wr_req_valid = 1'b1; wr_req_addr = 64'h10; wr_req_data = 64'hDEAD_BEEF; wr_req_strb = 8'h0F;
    step();                                   // T passed
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
    bus.WREADY = 1'b1;
    sample();
    total++; if ({bus.AWVALID, bus.WVALID} !== 2'b11) $display("FAIL wfirst_both_valid: got %b want 11", {bus.AWVALID, bus.WVALID}); else passed++;
    step();                                   // T+1: W handshake only
    bus.WREADY = 1'b0;
    sample();
    total++; if ({bus.AWVALID, bus.WVALID, bus.BREADY} !== 3'b100) $display("FAIL wfirst_w_dropped: got %b want 100", {bus.AWVALID, bus.WVALID, bus.BREADY}); else passed++;
    total++; if ({bus.AWADDR, bus.WDATA, bus.WSTRB} !== {64'h10, 64'hDEAD_BEEF, 8'h0F}) $display("FAIL wfirst_payload: got %h/%h/%h want 10/deadbeef/0f", bus.AWADDR, bus.WDATA, bus.WSTRB); else passed++;
    step();                                   // T+2
    bus.AWREADY = 1'b1;
    sample();
    total++; if ({bus.AWVALID, bus.AWADDR, bus.BREADY} !== {1'b1, 64'h10, 1'b0}) $display("FAIL wfirst_aw_stable: got %b/%h/%b want 1/10/0", bus.AWVALID, bus.AWADDR, bus.BREADY); else passed++;
    step();                                   // T+3: AW handshake
    bus.AWREADY = 1'b0; bus.BVALID = 1'b1; bus.BRESP = OKAY;
    sample();
    total++; if ({bus.AWVALID, bus.BREADY, wr_rsp_valid} !== 3'b010) $display("FAIL wfirst_bready: got %b want 010", {bus.AWVALID, bus.BREADY, wr_rsp_valid}); else passed++;
    step();                                   // B handshake
    bus.BVALID = 1'b0; wr_rsp_ready = 1'b1;
    sample();
    total++; if ({bus.BREADY, wr_rsp_valid, wr_rsp_err} !== 3'b010) $display("FAIL wfirst_done: got %b want 010", {bus.BREADY, wr_rsp_valid, wr_rsp_err}); else passed++;
    step();
    wr_rsp_ready = 1'b0;
    sample();
    total++; if ({wr_rsp_valid, wr_req_ready} !== 2'b01) $display("FAIL wfirst_idle: got %b want 01", {wr_rsp_valid, wr_req_ready}); else passed++;
  endtask

  task automatic test_errors();
    run_write(64'h20, 64'hCAFE_F00D_0000_0001, 8'hFF, SLVERR, 1'b1, "slverr_write");
    run_read(64'h40, 64'h0BAD_0BAD_0BAD_0BAD, DECERR, 1'b1, 0, "decerr_read");
  endtask

  task automatic test_back_to_back();
    run_read(64'h100, 64'hAAAA_5555_AAAA_5555, OKAY, 1'b0, 0, "b2b_read0");
    run_read(64'h108, 64'h0123_4567_89AB_CDEF, EXOKAY, 1'b0, 0, "b2b_read1");
    run_write(64'h200, 64'h1, 8'h01, OKAY, 1'b0, "b2b_write0");
    run_write(64'h208, 64'h2, 8'h80, OKAY, 1'b0, "b2b_write1");
  endtask

  task automatic test_backpressure();
    run_read(64'h300, 64'h5A5A_5A5A_A5A5_A5A5, OKAY, 1'b0, 5, "backpressure");
  endtask

  task automatic test_serialize();
    step();
    s_rd_req_valid = 1'b1; s_rd_req_addr = 64'h500;
    s_wr_req_valid = 1'b1; s_wr_req_addr = 64'h600; s_wr_req_data = 64'h77; s_wr_req_strb = 8'h03;
    sample();
    total++; if ({s_wr_req_ready, s_rd_req_ready} !== 2'b10) $display("FAIL ser_grant: got %b want 10", {s_wr_req_ready, s_rd_req_ready}); else passed++;
    step();                                   // write accepted at T
    s_wr_req_valid = 1'b0; sbus.AWREADY = 1'b1; sbus.WREADY = 1'b1;
    sample();
    total++; if ({sbus.AWVALID, sbus.ARVALID, s_rd_req_ready} !== 3'b100) $display("FAIL ser_write_first: got %b want 100", {sbus.AWVALID, sbus.ARVALID, s_rd_req_ready}); else passed++;
    step();
    sbus.AWREADY = 1'b0; sbus.WREADY = 1'b0;
    sample();
    total++; if ({sbus.BREADY, sbus.ARVALID, s_rd_req_ready} !== 3'b100) $display("FAIL ser_wresp: got %b want 100", {sbus.BREADY, sbus.ARVALID, s_rd_req_ready}); else passed++;
    step();
    sbus.BVALID = 1'b1; sbus.BRESP = OKAY;
    step();
    sbus.BVALID = 1'b0; s_wr_rsp_ready = 1'b1;
    sample();
    total++; if ({s_wr_rsp_valid, s_rd_req_ready} !== 2'b10) $display("FAIL ser_wdone: got %b want 10", {s_wr_rsp_valid, s_rd_req_ready}); else passed++;
    step();                                   // write response handshake done
    s_wr_rsp_ready = 1'b0;
    sample();
    total++; if ({s_rd_req_ready, s_wr_rsp_valid} !== 2'b10) $display("FAIL ser_read_released: got %b want 10", {s_rd_req_ready, s_wr_rsp_valid}); else passed++;
    step();                                   // read accepted
    s_rd_req_valid = 1'b0; sbus.ARREADY = 1'b1;
    sample();
    total++; if ({sbus.ARVALID, sbus.ARADDR, s_wr_req_ready} !== {1'b1, 64'h500, 1'b0}) $display("FAIL ser_read_issue: got %b/%h/%b want 1/500/0", sbus.ARVALID, sbus.ARADDR, s_wr_req_ready); else passed++;
    step();
    sbus.ARREADY = 1'b0;
    step();
    sbus.RVALID = 1'b1; sbus.RDATA = 64'hFEED_FACE_0000_1234; sbus.RRESP = OKAY;
    step();
    sbus.RVALID = 1'b0; s_rd_rsp_ready = 1'b1;
    sample();
    total++; if ({s_rd_rsp_valid, s_rd_rsp_data} !== {1'b1, 64'hFEED_FACE_0000_1234}) $display("FAIL ser_read_done: got %b/%h want 1/feedface00001234", s_rd_rsp_valid, s_rd_rsp_data); else passed++;
    step();
    s_rd_rsp_ready = 1'b0;
    sample();
    total++; if ({s_rd_req_ready, s_wr_req_ready} !== 2'b11) $display("FAIL ser_idle: got %b want 11", {s_rd_req_ready, s_wr_req_ready}); else passed++;
  endtask

  // Reset asserted mid-cycle with the write stuck in W_SEND and the read in R_DATA.
  task automatic test_reset_mid();
    logic [10:0] ctl;
    step();
    wr_req_valid = 1'b1; wr_req_addr = 64'h700; wr_req_data = 64'h99; wr_req_strb = 8'hF0;
    rd_req_valid = 1'b1; rd_req_addr = 64'h800;
    step();
    wr_req_valid = 1'b0; rd_req_valid = 1'b0; bus.ARREADY = 1'b1;
    step();
    bus.ARREADY = 1'b0;
    sample();
    total++; if ({bus.AWVALID, bus.WVALID, bus.RREADY} !== 3'b111) $display("FAIL midrst_setup: got %b want 111", {bus.AWVALID, bus.WVALID, bus.RREADY}); else passed++;
    #2 ARESET = 1'b1;
    #1;
    ctl = {rd_req_ready, wr_req_ready, rd_rsp_valid, wr_rsp_valid, rd_rsp_err, wr_rsp_err,
           bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY};
    total++; if (ctl !== 11'b0) $display("FAIL midrst_ctl: got %b want 0", ctl); else passed++;
    total++; if ({bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB} !== '0) $display("FAIL midrst_payload: got %h/%h/%h/%h want 0", bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB); else passed++;
    step();
    step();
    ARESET = 1'b0;
    sample();
    total++; if ({rd_req_ready, wr_req_ready, bus.AWVALID, bus.RREADY} !== 4'b1100) $display("FAIL midrst_idle: got %b want 1100", {rd_req_ready, wr_req_ready, bus.AWVALID, bus.RREADY}); else passed++;
    run_write(64'h900, 64'h1234, 8'h0C, OKAY, 1'b0, "post_rst_write");
    run_read(64'hA00, 64'h4321, OKAY, 1'b0, 0, "post_rst_read");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_write_w_first();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_serialize();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

Parametrised AXI4-Lite master bridging the core's fetch/LSU request ports onto an AXI4-Lite bus. Each of the read and write paths has a core-side valid/ready request port, a core-side response port and its own state machine. AW and W handshakes are tracked independently, and the bridge waits for the B/R response before reporting completion with an error flag. An optional serialise mode enforces write-before-read ordering for LSU use.

## Interface
Parameters:
- ADDR_W, 64, address width of core requests and AWADDR/ARADDR
- DATA_W, 64, data width; legal values 32, 64
- STRB_W, DATA_W/8, derived write-strobe width
- SERIALIZE, 0, 1 = at most one transaction (read or write) in flight bus-wide; simultaneous requests grant write first

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, asynchronous, active-high
- rd_req_valid / rd_req_ready  in / out  1  read request handshake
- rd_req_addr  in  ADDR_W  read address
- rd_rsp_valid / rd_rsp_ready  out / in  1  read response handshake
- rd_rsp_data  out  DATA_W  read data, registered
- rd_rsp_err  out  1  RRESP[1] of the completed read
- wr_req_valid / wr_req_ready  in / out  1  write request handshake
- wr_req_addr, wr_req_data, wr_req_strb  in  ADDR_W, DATA_W, STRB_W  write payload
- wr_rsp_valid / wr_rsp_ready  out / in  1  write completion handshake
- wr_rsp_err  out  1  BRESP[1] of the completed write
- AWVALID/AWREADY, AWADDR, AWPROT  out/in, out, out  1, ADDR_W, 3  write address channel
- WVALID/WREADY, WDATA, WSTRB  out/in, out, out  1, DATA_W, STRB_W  write data channel
- BVALID/BREADY, BRESP  in/out, in  1, 2  write response channel
- ARVALID/ARREADY, ARADDR, ARPROT  out/in, out, out  1, ADDR_W, 3  read address channel
- RVALID/RREADY, RDATA, RRESP  in/out, in, in  1, DATA_W, 2  read data channel

## Operation
- Write FSM: W_IDLE -> W_SEND -> W_RESP -> W_DONE -> W_IDLE.
  - W_IDLE: wr_req_ready=1, subject to the SERIALIZE gate. On handshake, latch addr/data/strb and clear the aw_done/w_done flags.
  - W_SEND: AWVALID=!aw_done and WVALID=!w_done. Each flag sets on its own handshake. Leave when both flags are set, including when both handshakes complete in the same cycle.
  - W_RESP: BREADY=1. On BVALID, latch wr_rsp_err=BRESP[1].
  - W_DONE: wr_rsp_valid=1, held until wr_rsp_ready.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_DONE -> R_IDLE.
  - R_IDLE: rd_req_ready=1, subject to the SERIALIZE gate. On handshake, latch the address.
  - R_ADDR: ARVALID=1 until ARREADY.
  - R_DATA: RREADY=1. On RVALID, latch RDATA and RRESP[1].
  - R_DONE: rd_rsp_valid=1, held until rd_rsp_ready.
- VALID stability: every VALID, once raised, holds its payload stable and stays high until its handshake. Payloads are never zeroed while VALID is high.
- AWPROT = ARPROT = 3'b000, constant.
- SERIALIZE=1:
  - rd_req_ready = R_IDLE && W_IDLE && !wr_req_valid.
  - wr_req_ready = W_IDLE && R_IDLE.
- SERIALIZE=0: the read and write FSMs are fully independent.
- Response data: rd_rsp_data holds the last read value outside R_DONE. Consumers qualify it with rd_rsp_valid.

## Timing
- Reset: while ARESET is high, all FSMs are in IDLE; all VALID/READY outputs and response flags are 0; AWADDR, ARADDR, WDATA, WSTRB and rd_rsp_data are 0. Reset mid-transaction drops every VALID immediately (asynchronous) and discards latched state.
- Request to bus:
  - Core handshake at edge T: AWVALID/WVALID/ARVALID are high after edge T.
  - A zero-wait slave handshakes at edge T+1.
- Read latency, zero-wait slave (ARREADY and RVALID in the cycle after the bus request): rd_rsp_valid high after edge T+3, i.e. 3 cycles.
- Write latency, zero-wait slave: wr_rsp_valid high after edge T+3.
- Back-to-back: the FSM returns to IDLE on the response-handshake edge; the next request can be accepted in the following cycle. Maximum throughput is 1 transaction per 4 cycles per direction.
- Readiness on entry: BREADY/RREADY are 0 outside W_RESP/R_DATA. They are asserted in the first cycle of those states, not speculatively.
- Ready outputs are combinational from state plus wr_req_valid; there are no combinational paths from AXI inputs to core-side ready.

## Structure
- Shared package axi_lite_pkg:
  - resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - one-hot state encodings for the write and read FSMs;
  - PROT_DEFAULT=3'b000.
- Sub-modules: none. The two FSMs live in-line.

## Test plan
- Single read, zero-wait slave, addr 0x8000_0000, RDATA=0x1122334455667788, RRESP=OKAY -> rd_rsp_valid 3 cycles after the request, data matches, rd_rsp_err=0.
- Write where the slave asserts WREADY 2 cycles before AWREADY, addr 0x10, data 0xDEADBEEF, strb 0x0F -> WVALID drops first, AWVALID stays high with a stable payload, one BREADY cycle, wr_rsp_err=0.
- Write with BRESP=SLVERR, then a read with RRESP=DECERR -> wr_rsp_err=1, rd_rsp_err=1.
- SERIALIZE=1, rd_req_valid and wr_req_valid rise in the same cycle -> write granted, rd_req_ready=0 until the write response handshake, then the read proceeds.
- Response backpressure: rd_rsp_ready held low for 5 cycles -> rd_rsp_valid and data stable for those 5 cycles, no new ARVALID.
- ARESET pulsed while in R_DATA and W_SEND -> all VALIDs 0 during reset, both FSMs idle, next requests complete normally.
